// File: rtl/carwash_sequencer.sv
// rtl/carwash_sequencer.sv - ten-stage car-wash controller with speed prescaler, options and door pause
module carwash_sequencer #(
  parameter int CW          = 26,
  parameter int TICK_FAST   = 10_000_000,
  parameter int TICK_STD    = 25_000_000,
  parameter int TICK_SLOW   = 50_000_000,
  parameter int STAGE_TICKS = 5
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       car_pb,
  input  logic       wax_pb,
  input  logic       dwash_pb,
  input  logic [1:0] speed_sel,
  input  logic [1:0] pkg_sel,
  input  logic       door_open,
  output logic [9:0] state,
  output logic [9:0] leds,
  output logic [7:0] remaining,
  output logic       tick,
  output logic       busy,
  output logic       done,
  output logic       pkg_err
);

  localparam logic [9:0] S_IDLE  = 10'b10_0000_0000;
  localparam logic [9:0] S_SOAK  = 10'b01_0000_0000;
  localparam logic [9:0] S_SOAP  = 10'b00_1000_0000;
  localparam logic [9:0] S_BRUSH = 10'b00_0100_0000;
  localparam logic [9:0] S_BLAST = 10'b00_0010_0000;
  localparam logic [9:0] S_DWASH = 10'b00_0001_0000;
  localparam logic [9:0] S_DRY   = 10'b00_0000_1000;
  localparam logic [9:0] S_WAX   = 10'b00_0000_0100;
  localparam logic [9:0] S_TIREC = 10'b00_0000_0010;
  localparam logic [9:0] S_END   = 10'b00_0000_0001;

  localparam logic [CW-1:0] P_FAST       = CW'(TICK_FAST);
  localparam logic [CW-1:0] P_STD        = CW'(TICK_STD);
  localparam logic [CW-1:0] P_SLOW       = CW'(TICK_SLOW);
  localparam logic [CW-1:0] P_BLINK_LAST = CW'(TICK_STD - 1);
  localparam logic [7:0]    ST_LOAD      = 8'(STAGE_TICKS);

  logic [9:0]    r_state;
  logic [7:0]    r_remaining;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_period;
  logic [CW-1:0] r_blink_cnt;
  logic          r_blink;
  logic          r_done;
  logic          r_car_req;
  logic          r_wax;
  logic          r_dw;
  logic          r_touchless;
  logic          r_car_d;
  logic          r_wax_d;
  logic          r_dw_d;

  logic          w_pause;
  logic          w_wrap;
  logic          w_tick;
  logic          w_car_ev;
  logic          w_wax_ev;
  logic          w_dw_ev;
  logic          w_pkg_ok;
  logic [CW-1:0] w_sel_period;
  logic [9:0]    w_next;

  assign w_pause  = door_open && (r_state != S_IDLE);
  assign w_wrap   = (r_cnt == r_period - CW'(1));
  assign w_tick   = w_wrap && !w_pause;
  assign w_car_ev = car_pb && !r_car_d;
  assign w_wax_ev = wax_pb && !r_wax_d;
  assign w_dw_ev  = dwash_pb && !r_dw_d;
  assign w_pkg_ok = (pkg_sel == 2'b01) || (pkg_sel == 2'b10);

  assign state     = r_state;
  assign leds      = w_pause ? {10{r_blink}} : r_state;
  assign remaining = r_remaining;
  assign tick      = w_tick;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign pkg_err   = (r_state == S_IDLE) && !w_pkg_ok;

  // Map the speed switches to a prescaler period; 00 and 11 both fall back to standard
  always_comb begin
    w_sel_period = P_STD;
    case (speed_sel)
      2'b01:   w_sel_period = P_FAST;
      2'b10:   w_sel_period = P_SLOW;
      default: w_sel_period = P_STD;
    endcase
  end

  // Next included stage, using the option flags as registered before this clock
  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_SOAK:  w_next = S_SOAP;
      S_SOAP:  w_next = r_touchless ? S_BLAST : S_BRUSH;
      S_BRUSH: w_next = S_BLAST;
      S_BLAST: w_next = r_dw ? S_DWASH : S_DRY;
      S_DWASH: w_next = S_DRY;
      S_DRY:   w_next = r_wax ? S_WAX : S_TIREC;
      S_WAX:   w_next = S_TIREC;
      S_TIREC: w_next = S_END;
      default: w_next = S_IDLE;
    endcase
  end

  // Prescaler: frozen while paused so a lost tick recurs after resume; period re-sampled at wrap
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      r_cnt    <= '0;
      r_period <= w_sel_period;
    end else if (!w_pause) begin
      if (w_wrap) begin
        r_cnt    <= '0;
        r_period <= w_sel_period;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // Blink generator: idle and dark outside a pause, toggles every standard period inside one
  always_ff @(posedge CLOCK_50) begin
    if (RESET || !w_pause) begin
      r_blink_cnt <= '0;
      r_blink     <= 1'b0;
    end else if (r_blink_cnt == P_BLINK_LAST) begin
      r_blink_cnt <= '0;
      r_blink     <= ~r_blink;
    end else begin
      r_blink_cnt <= r_blink_cnt + CW'(1);
    end
  end

  // Button edge capture, option flags and the stage sequencer
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_done      <= 1'b0;
      r_car_req   <= 1'b0;
      r_wax       <= 1'b0;
      r_dw        <= 1'b0;
      r_touchless <= 1'b0;
      r_car_d     <= 1'b0;
      r_wax_d     <= 1'b0;
      r_dw_d      <= 1'b0;
    end else begin
      r_car_d <= car_pb;
      r_wax_d <= wax_pb;
      r_dw_d  <= dwash_pb;
      r_done  <= 1'b0;
      if (r_state != S_END) begin
        if (w_wax_ev) r_wax <= 1'b1;
        if (w_dw_ev)  r_dw  <= 1'b1;
      end
      if (r_state == S_IDLE) begin
        if (w_tick && r_car_req && w_pkg_ok) begin
          r_state     <= S_SOAK;
          r_remaining <= ST_LOAD;
          r_touchless <= (pkg_sel == 2'b10);
          r_car_req   <= 1'b0;
        end else if (w_car_ev) begin
          r_car_req <= 1'b1;
        end
      end else if (w_tick) begin
        if (r_remaining == 8'd1) begin
          r_state <= w_next;
          if (r_state == S_END) begin
            r_remaining <= '0;
            r_done      <= 1'b1;
            r_car_req   <= 1'b0;
            r_wax       <= 1'b0;
            r_dw        <= 1'b0;
          end else begin
            r_remaining <= ST_LOAD;
          end
        end else begin
          r_remaining <= r_remaining - 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_carwash_sequencer.sv
// tb/tb_carwash_sequencer.sv - randomized self-checking bench for carwash_sequencer
module tb_carwash_sequencer;

  localparam logic [9:0] S_IDLE  = 10'b10_0000_0000;
  localparam logic [9:0] S_SOAK  = 10'b01_0000_0000;
  localparam logic [9:0] S_SOAP  = 10'b00_1000_0000;
  localparam logic [9:0] S_BRUSH = 10'b00_0100_0000;
  localparam logic [9:0] S_BLAST = 10'b00_0010_0000;
  localparam logic [9:0] S_DWASH = 10'b00_0001_0000;
  localparam logic [9:0] S_DRY   = 10'b00_0000_1000;
  localparam logic [9:0] S_WAX   = 10'b00_0000_0100;
  localparam logic [9:0] S_TIREC = 10'b00_0000_0010;
  localparam logic [9:0] S_END   = 10'b00_0000_0001;
  localparam int ST = 2;

  logic       clk = 1'b0;
  logic       RESET = 1'b1;
  logic       car_pb = 1'b0;
  logic       wax_pb = 1'b0;
  logic       dwash_pb = 1'b0;
  logic [1:0] speed_sel = 2'b00;
  logic [1:0] pkg_sel = 2'b01;
  logic       door_open = 1'b0;
  logic [9:0] state;
  logic [9:0] leds;
  logic [7:0] remaining;
  logic       tick;
  logic       busy;
  logic       done;
  logic       pkg_err;

  int n_chk = 0;
  int n_fail = 0;
  int edge_n = 0;
  logic [9:0] exp_q[$];

  carwash_sequencer #(
    .CW(8), .TICK_FAST(2), .TICK_STD(3), .TICK_SLOW(4), .STAGE_TICKS(ST)
  ) dut (
    .CLOCK_50(clk), .RESET(RESET), .car_pb(car_pb), .wax_pb(wax_pb),
    .dwash_pb(dwash_pb), .speed_sel(speed_sel), .pkg_sel(pkg_sel),
    .door_open(door_open), .state(state), .leds(leds), .remaining(remaining),
    .tick(tick), .busy(busy), .done(done), .pkg_err(pkg_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic int period_of(input logic [1:0] spd);
    if (spd == 2'b01) return 2;
    if (spd == 2'b10) return 4;
    return 3;
  endfunction

  // Expected stage list straight from the wash rules
  function automatic void build_exp(input bit touchless, input bit wax, input bit dw);
    exp_q.delete();
    exp_q.push_back(S_SOAK);
    exp_q.push_back(S_SOAP);
    if (!touchless) exp_q.push_back(S_BRUSH);
    exp_q.push_back(S_BLAST);
    if (dw) exp_q.push_back(S_DWASH);
    exp_q.push_back(S_DRY);
    if (wax) exp_q.push_back(S_WAX);
    exp_q.push_back(S_TIREC);
    exp_q.push_back(S_END);
  endfunction

  task automatic start_car(input logic [1:0] pk, input logic [1:0] spd, input bit wx,
                           input bit dw, output int entry);
    pkg_sel = pk;
    speed_sel = spd;
    repeat (10) step();
    car_pb = 1'b1;
    step();
    car_pb = 1'b0;
    entry = -1;
    for (int i = 0; i < 20 && entry < 0; i++) begin
      step();
      if (state === S_SOAK) entry = edge_n;
    end
    chk("soak_entry", int'(entry >= 0), 1);
    if (entry >= 0) begin
      wax_pb = wx;
      dwash_pb = dw;
      step();
      wax_pb = 1'b0;
      dwash_pb = 1'b0;
    end
  endtask

  task automatic finish_run(input int entry, input int p, input int pidx, input int plen);
    logic [9:0] obs[$];
    logic [9:0] last;
    logic [9:0] st0;
    logic [7:0] rem0;
    logic       b;
    int done_at;
    bit paused;
    done_at = -1;
    paused = 0;
    obs.push_back(S_SOAK);
    last = S_SOAK;
    for (int i = 0; i < 2000 && done_at < 0; i++) begin
      step();
      if (done === 1'b1) begin
        done_at = edge_n;
        chk("done_state_idle", int'(state), int'(S_IDLE));
        chk("done_remaining", int'(remaining), 0);
        chk("done_busy", int'(busy), 0);
      end else begin
        if (state !== last) begin
          last = state;
          if (state !== S_IDLE) obs.push_back(state);
        end
        if (!paused && plen > 0 && pidx < exp_q.size() && state === exp_q[pidx]) begin
          paused = 1;
          st0 = state;
          rem0 = remaining;
          door_open = 1'b1;
          for (int k = 1; k <= plen; k++) begin
            step();
            b = ((k / 3) % 2) == 1;
            chk($sformatf("pause_state_k%0d", k), int'(state), int'(st0));
            chk($sformatf("pause_rem_k%0d", k), int'(remaining), int'(rem0));
            chk($sformatf("pause_leds_k%0d", k), int'(leds), int'({10{b}}));
            chk($sformatf("pause_tick_k%0d", k), int'(tick), 0);
          end
          door_open = 1'b0;
        end
      end
    end
    chk("done_seen", int'(done_at >= 0), 1);
    chk("stage_count", obs.size(), exp_q.size());
    for (int k = 0; k < obs.size() && k < exp_q.size(); k++)
      chk($sformatf("stage_%0d", k), int'(obs[k]), int'(exp_q[k]));
    if (done_at >= 0) chk("run_cycles", done_at - entry, exp_q.size() * ST * p + plen);
    step();
    chk("done_one_cycle", int'(done), 0);
  endtask

  initial begin
    int entry;
    int found;
    int t0;
    int tt[3];
    int nt;
    int dn;
    int pidx;
    int plen;
    logic [1:0] pk;
    logic [1:0] sp;
    bit wx;
    bit dw;

    // Reset values
    repeat (3) step();
    chk("rst_state", int'(state), int'(S_IDLE));
    chk("rst_leds", int'(leds), int'(S_IDLE));
    chk("rst_remaining", int'(remaining), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pkg_err", int'(pkg_err), 0);
    RESET = 1'b0;

    // Soft cloth, standard, no options: 7 stages, 42 cycles
    build_exp(0, 0, 0);
    start_car(2'b01, 2'b00, 0, 0, entry);
    if (entry >= 0) finish_run(entry, 3, 0, 0);

    // Touchless, fast, wax and double wash: 8 stages, 32 cycles
    build_exp(1, 1, 1);
    start_car(2'b10, 2'b01, 1, 1, entry);
    if (entry >= 0) finish_run(entry, 2, 0, 0);

    // Door open 10 cycles in BRUSH; options from previous car must not carry over
    build_exp(0, 0, 0);
    start_car(2'b01, 2'b00, 0, 0, entry);
    if (entry >= 0) finish_run(entry, 3, 2, 10);

    // Invalid package holds the car request until a valid package appears
    pkg_sel = 2'b11;
    speed_sel = 2'b00;
    repeat (5) step();
    car_pb = 1'b1;
    step();
    car_pb = 1'b0;
    repeat (8) step();
    chk("pkgerr_flag", int'(pkg_err), 1);
    chk("pkgerr_idle", int'(state), int'(S_IDLE));
    pkg_sel = 2'b01;
    entry = -1;
    for (int i = 0; i < 6 && entry < 0; i++) begin
      step();
      if (state === S_SOAK) entry = edge_n;
    end
    chk("pkgerr_soak_no_press", int'(entry >= 0), 1);
    chk("pkgerr_cleared", int'(pkg_err), 0);
    build_exp(0, 0, 0);
    if (entry >= 0) finish_run(entry, 3, 0, 0);

    // Reset in DRY discards the run and the wax option
    start_car(2'b01, 2'b00, 1, 0, entry);
    found = 0;
    for (int i = 0; i < 300 && found == 0; i++) begin
      step();
      if (state === S_DRY) found = 1;
    end
    chk("reach_dry", found, 1);
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    chk("midrst_state", int'(state), int'(S_IDLE));
    chk("midrst_remaining", int'(remaining), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    dn = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done === 1'b1) dn++;
    end
    chk("midrst_no_done", dn, 0);
    build_exp(0, 0, 0);
    start_car(2'b01, 2'b00, 0, 0, entry);
    if (entry >= 0) finish_run(entry, 3, 0, 0);

    // Speed change mid-period takes effect from the next period
    speed_sel = 2'b01;
    repeat (12) step();
    t0 = -1;
    for (int i = 0; i < 10 && t0 < 0; i++) begin
      step();
      if (tick === 1'b1) t0 = edge_n;
    end
    step();
    speed_sel = 2'b10;
    nt = 0;
    for (int i = 0; i < 30 && nt < 3; i++) begin
      step();
      if (tick === 1'b1) begin
        tt[nt] = edge_n;
        nt++;
      end
    end
    chk("speed_ticks_seen", int'(t0 >= 0 && nt == 3), 1);
    if (t0 >= 0 && nt == 3) begin
      chk("speed_old_period", tt[0] - t0, 2);
      chk("speed_new_period1", tt[1] - tt[0], 4);
      chk("speed_new_period2", tt[2] - tt[1], 4);
    end

    // Door open in IDLE has no effect
    door_open = 1'b1;
    nt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (tick === 1'b1) nt++;
    end
    chk("idle_door_leds", int'(leds), int'(S_IDLE));
    chk("idle_door_ticks", int'(nt > 0), 1);
    door_open = 1'b0;

    // Randomized runs against the stage-list model
    for (int r = 0; r < 6; r++) begin
      pk = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
      sp = 2'($urandom_range(0, 3));
      wx = 1'($urandom_range(0, 1));
      dw = 1'($urandom_range(0, 1));
      plen = int'($urandom_range(0, 7));
      build_exp(pk == 2'b10, wx, dw);
      pidx = int'($urandom_range(0, exp_q.size() - 1));
      start_car(pk, sp, wx, dw, entry);
      if (entry >= 0) finish_run(entry, period_of(sp), pidx, plen);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
